case_result_fifo: RTL

Downstream capture stage for the case-selection combinational block. On each enabled clock it samples the block's 8-bit `result` together with the 2-bit `select` that produced it, and buffers the pair in a small first-in-first-out store. The pair is presented to a consumer through a valid/ready handshake. The block tracks occupancy and counts samples lost when the buffer is full, flagging overflow with a sticky `OV`.

---
 rtl/case_result_fifo_if.sv | 30 +++
 rtl/case_result_fifo.sv | 64 ++++++
 2 files changed

// File: rtl/case_result_fifo_if.sv
// case_result_fifo_if: capture, handshake and status signals of the case-result FIFO.
// The master is the producer/consumer side; the slave is the FIFO itself.
interface case_result_fifo_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 2
);
    logic                    EN;
    logic                    CLR;
    logic [DATA_W-1:0]       result;
    logic [SEL_W-1:0]        select;
    logic [SEL_W+DATA_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_W:0]         count;
    logic                    full;
    logic                    empty;
    logic [7:0]              drop_cnt;
    logic                    OV;

    modport master (
        output EN, CLR, result, select, out_ready,
        input  out_data, out_valid, count, full, empty, drop_cnt, OV
    );

    modport slave (
        input  EN, CLR, result, select, out_ready,
        output out_data, out_valid, count, full, empty, drop_cnt, OV
    );
endinterface

// File: rtl/case_result_fifo.sv
// case_result_fifo: show-ahead FIFO capturing {select, result} pairs, with
// saturating drop counter and sticky overflow flag for captures into a full buffer.
module case_result_fifo #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input logic              clk,
    input logic              Reset,
    case_result_fifo_if.slave bus
);
    localparam int W  = SEL_W + DATA_W;
    localparam int CW = ADDR_W + 1;

    logic [W-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        drop_q, drop_d;
    logic              ov_q, ov_d;
    logic              push, pop, drop;

    assign bus.empty     = count_q == '0;
    assign bus.full      = count_q == CW'(DEPTH);
    assign bus.out_valid = !bus.empty;
    assign bus.out_data  = bus.empty ? '0 : mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.OV        = ov_q;

    // A full buffer still accepts a capture when the head leaves on the same edge.
    assign pop  = bus.out_valid && bus.out_ready;
    assign push = bus.EN && (!bus.full || pop);
    assign drop = bus.EN && bus.full && !pop;

    always_comb begin
        wr_ptr_d = bus.CLR ? '0 : wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = bus.CLR ? '0 : rd_ptr_q + ADDR_W'(pop);
        count_d  = bus.CLR ? '0 : count_q + CW'(push) - CW'(pop);
        drop_d   = bus.CLR ? '0 : drop_q + 8'(drop && drop_q != 8'hFF);
        ov_d     = !bus.CLR && (ov_q || drop);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ov_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            ov_q     <= ov_d;
        end
    end

    // Storage needs no reset: only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push && !bus.CLR) mem_q[wr_ptr_q] <= {bus.select, bus.result};
    end
endmodule
